id_ex_stage: RTL

ID/EX pipeline stage sitting directly upstream of the ALU in the MIPS32 pipeline. It registers one decoded instruction and forwards register values from EX/MEM and MEM/WB. It also selects the ALU A/B operands and the 3-bit ALU opcode, and applies a valid/ready handshake on both sides. EX/MEM load-use hazards are resolved by holding the entry until the load data reaches MEM/WB.

---
 rtl/id_ex_stage.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the MIPS32 pipeline: holds one decoded instruction,
// forwards from EX/MEM and MEM/WB, selects ALU operands and stalls on load-use.
module id_ex_stage (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] id_pc,
    input  logic [4:0]  id_rs_addr,
    input  logic [4:0]  id_rt_addr,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_shamt,
    input  logic        id_alusrc,
    input  logic        id_shift,
    input  logic [2:0]  id_aluop,
    input  logic        id_wr_en,
    input  logic [4:0]  id_wr_addr,
    input  logic        id_is_load,

    input  logic        flush,

    input  logic        exmem_wr_en,
    input  logic [4:0]  exmem_wr_addr,
    input  logic [31:0] exmem_result,
    input  logic        exmem_is_load,
    input  logic        memwb_wr_en,
    input  logic [4:0]  memwb_wr_addr,
    input  logic [31:0] memwb_data,

    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [31:0] ex_a,
    output logic [31:0] ex_b,
    output logic [2:0]  ex_aluop,
    output logic [31:0] ex_pc,
    output logic        ex_wr_en,
    output logic [4:0]  ex_wr_addr,
    output logic        ex_is_load,
    output logic [31:0] ex_store_data
);

    logic        full_q, full_d;
    logic [31:0] pc_q;
    logic [4:0]  rs_addr_q, rt_addr_q;
    logic [31:0] rs_data_q, rs_data_d;
    logic [31:0] rt_data_q, rt_data_d;
    logic [31:0] imm_q;
    logic [4:0]  shamt_q;
    logic        alusrc_q, shift_q;
    logic [2:0]  aluop_q;
    logic        wr_en_q;
    logic [4:0]  wr_addr_q;
    logic        is_load_q;

    logic [31:0] fwd_rs, fwd_rt;
    logic        ld_rs, ld_rt, hazard;
    logic        accept, consume, load_en;

    // A load in EX/MEM has no data yet, so it is excluded from forwarding.
    always_comb begin
        fwd_rs = rs_data_q;
        if (rs_addr_q != 5'd0 && exmem_wr_en && !exmem_is_load && exmem_wr_addr == rs_addr_q)
            fwd_rs = exmem_result;
        else if (rs_addr_q != 5'd0 && memwb_wr_en && memwb_wr_addr == rs_addr_q)
            fwd_rs = memwb_data;
    end

    always_comb begin
        fwd_rt = rt_data_q;
        if (rt_addr_q != 5'd0 && exmem_wr_en && !exmem_is_load && exmem_wr_addr == rt_addr_q)
            fwd_rt = exmem_result;
        else if (rt_addr_q != 5'd0 && memwb_wr_en && memwb_wr_addr == rt_addr_q)
            fwd_rt = memwb_data;
    end

    assign ld_rs = exmem_wr_en && exmem_is_load && exmem_wr_addr != 5'd0 && exmem_wr_addr == rs_addr_q;
    assign ld_rt = exmem_wr_en && exmem_is_load && exmem_wr_addr != 5'd0 && exmem_wr_addr == rt_addr_q;

    // rt always feeds store data, so it stalls even when B takes the immediate.
    assign hazard   = (!shift_q && ld_rs) || ld_rt;
    assign ex_valid = full_q && !hazard;
    assign in_ready = !full_q || (ex_valid && ex_ready);
    assign accept   = in_valid && in_ready;
    assign consume  = ex_valid && ex_ready;
    assign load_en  = !flush && accept;

    always_comb begin
        full_d    = full_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        if (flush) begin
            full_d = 1'b0;
        end else if (accept) begin
            full_d    = 1'b1;
            rs_data_d = id_rs_data;
            rt_data_d = id_rt_data;
        end else if (consume) begin
            full_d = 1'b0;
        end else if (full_q) begin
            // capture forwarded values before the producer retires
            rs_data_d = fwd_rs;
            rt_data_d = fwd_rt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full_q    <= 1'b0;
            rs_data_q <= 32'd0;
            rt_data_q <= 32'd0;
        end else begin
            full_q    <= full_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q      <= 32'd0;
            rs_addr_q <= 5'd0;
            rt_addr_q <= 5'd0;
            imm_q     <= 32'd0;
            shamt_q   <= 5'd0;
            alusrc_q  <= 1'b0;
            shift_q   <= 1'b0;
            aluop_q   <= 3'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 5'd0;
            is_load_q <= 1'b0;
        end else if (load_en) begin
            pc_q      <= id_pc;
            rs_addr_q <= id_rs_addr;
            rt_addr_q <= id_rt_addr;
            imm_q     <= id_imm;
            shamt_q   <= id_shamt;
            alusrc_q  <= id_alusrc;
            shift_q   <= id_shift;
            aluop_q   <= id_aluop;
            wr_en_q   <= id_wr_en;
            wr_addr_q <= id_wr_addr;
            is_load_q <= id_is_load;
        end
    end

    assign ex_a          = shift_q ? fwd_rt : fwd_rs;
    assign ex_b          = shift_q ? {27'd0, shamt_q} : (alusrc_q ? imm_q : fwd_rt);
    assign ex_aluop      = aluop_q;
    assign ex_pc         = pc_q;
    assign ex_wr_en      = wr_en_q;
    assign ex_wr_addr    = wr_addr_q;
    assign ex_is_load    = is_load_q;
    assign ex_store_data = fwd_rt;

endmodule
